// File: rtl/event_window_counter.sv
// event_window_counter
//   Windowed event counting: a reference cycle counter plus NUM_CH per-channel
//   event counters. The window runs one-shot (stop in DONE) or periodic
//   (snapshot the counts and restart). window_len of 0 means free-run.
//   Optional build macro EVENT_WINDOW_COUNTER_SATURATE_EN: counters stick at
//   all-ones instead of wrapping to zero. Overflow flags are sticky either way.

// One channel: live count, periodic snapshot, sticky overflow.
module ewc_lane #(
  parameter int WIDTH = 64
) (
  input  logic             pClk,
  input  logic             SoftReset,
  input  logic             clear,
  input  logic             start,
  input  logic             cnt_en,
  input  logic             snap,
  input  logic             ev,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] snapshot,
  output logic             ovf
);
  logic             at_max;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] nxt;

  assign at_max = &count;
`ifdef EVENT_WINDOW_COUNTER_SATURATE_EN
  assign inc = at_max ? count : count + 1'b1;
`else
  assign inc = count + 1'b1;
`endif
  // the end-of-window cycle's own event is part of the snapshot
  assign nxt = ev ? inc : count;

  // count, snapshot on periodic window end, sticky overflow
  always_ff @(posedge pClk) begin
    if (SoftReset || clear) begin
      count    <= '0;
      snapshot <= '0;
      ovf      <= 1'b0;
    end else if (start) begin
      count <= '0;
    end else if (cnt_en) begin
      if (ev && at_max) ovf <= 1'b1;
      if (snap) begin
        snapshot <= nxt;
        count    <= '0;
      end else begin
        count <= nxt;
      end
    end
  end
endmodule

module event_window_counter #(
  parameter int WIDTH  = 64,
  parameter int NUM_CH = 4
) (
  input  logic                    pClk,
  input  logic                    SoftReset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [WIDTH-1:0]        window_len,
  input  logic [NUM_CH-1:0]       ch_event,
  output logic [WIDTH-1:0]        ref_count,
  output logic [NUM_CH*WIDTH-1:0] ch_count,
  output logic [NUM_CH*WIDTH-1:0] ch_snapshot,
  output logic                    snapshot_valid,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH:0]         overflow
);
  // bit 0 = RUN, bit 1 = DONE, so busy/done come straight off the state flops
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]                   state;
  logic                         enable_q;
  logic                         mode_q;
  logic [WIDTH-1:0]             wlen_q;
  logic                         start;
  logic                         run;
  logic                         wend;
  logic                         snap;
  logic [WIDTH-1:0]             ref_inc;
  logic                         ref_ovf;
  logic [NUM_CH-1:0][WIDTH-1:0] cnt_a;
  logic [NUM_CH-1:0][WIDTH-1:0] snap_a;
  logic [NUM_CH-1:0]            ch_ovf;

  assign start = (state == ST_IDLE) && enable_q;
  assign run   = (state == ST_RUN) && enable_q;
  assign wend  = run && (wlen_q != '0) && ((ref_count + 1'b1) == wlen_q);
  assign snap  = wend && mode_q;

`ifdef EVENT_WINDOW_COUNTER_SATURATE_EN
  assign ref_inc = (&ref_count) ? ref_count : ref_count + 1'b1;
`else
  assign ref_inc = ref_count + 1'b1;
`endif

  // control: enable pipeline, state, latched window config, snapshot strobe
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state          <= ST_IDLE;
      enable_q       <= 1'b0;
      mode_q         <= 1'b0;
      wlen_q         <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      enable_q <= enable;
      if (clear) begin
        state          <= ST_IDLE;
        snapshot_valid <= 1'b0;
      end else begin
        snapshot_valid <= snap;
        case (state)
          ST_IDLE: if (enable_q) begin
            state  <= ST_RUN;
            mode_q <= mode;
            wlen_q <= window_len;
          end
          ST_RUN: begin
            if (!enable_q)           state <= ST_IDLE;
            else if (wend && !mode_q) state <= ST_DONE;
          end
          ST_DONE: if (!enable_q) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // reference cycle counter; one-shot end lands exactly on window_len
  always_ff @(posedge pClk) begin
    if (SoftReset || clear) begin
      ref_count <= '0;
      ref_ovf   <= 1'b0;
    end else if (start) begin
      ref_count <= '0;
    end else if (run) begin
      if (&ref_count) ref_ovf <= 1'b1;
      ref_count <= snap ? '0 : ref_inc;
    end
  end

  ewc_lane #(.WIDTH(WIDTH)) u_lane [NUM_CH-1:0] (
    .pClk     (pClk),
    .SoftReset(SoftReset),
    .clear    (clear),
    .start    (start),
    .cnt_en   (run),
    .snap     (snap),
    .ev       (ch_event),
    .count    (cnt_a),
    .snapshot (snap_a),
    .ovf      (ch_ovf)
  );

  assign ch_count    = cnt_a;
  assign ch_snapshot = snap_a;
  assign busy        = state[0];
  assign done        = state[1];
  assign overflow    = {ref_ovf, ch_ovf};
endmodule

// File: tb/tb_event_window_counter.sv
// Bench for event_window_counter: a WIDTH=16 instance for windowing behaviour
// and a WIDTH=4 instance sharing the same inputs for counter overflow.
module tb_event_window_counter;
  localparam int W  = 16;
  localparam int W4 = 4;
  localparam int N  = 4;
`ifdef EVENT_WINDOW_COUNTER_SATURATE_EN
  localparam logic [W4-1:0] EXP_OVF_CNT = 4'd15;
`else
  localparam logic [W4-1:0] EXP_OVF_CNT = 4'd1;
`endif

  logic          pClk = 1'b0;
  logic          SoftReset, clear, enable, mode;
  logic [W-1:0]  window_len;
  logic [N-1:0]  ch_event;
  logic [W-1:0]  ref_count;
  logic [N*W-1:0] ch_count, ch_snapshot;
  logic          snapshot_valid, busy, done;
  logic [N:0]    overflow;
  logic [W4-1:0] ref_count4;
  logic [N*W4-1:0] ch_count4, ch_snapshot4;
  logic          snapshot_valid4, busy4, done4;
  logic [N:0]    overflow4;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 pClk = ~pClk;

  event_window_counter #(.WIDTH(W), .NUM_CH(N)) u_dut (
    .pClk(pClk), .SoftReset(SoftReset), .clear(clear), .enable(enable),
    .mode(mode), .window_len(window_len), .ch_event(ch_event),
    .ref_count(ref_count), .ch_count(ch_count), .ch_snapshot(ch_snapshot),
    .snapshot_valid(snapshot_valid), .busy(busy), .done(done), .overflow(overflow)
  );

  event_window_counter #(.WIDTH(W4), .NUM_CH(N)) u_dut4 (
    .pClk(pClk), .SoftReset(SoftReset), .clear(clear), .enable(enable),
    .mode(mode), .window_len(window_len[W4-1:0]), .ch_event(ch_event),
    .ref_count(ref_count4), .ch_count(ch_count4), .ch_snapshot(ch_snapshot4),
    .snapshot_valid(snapshot_valid4), .busy(busy4), .done(done4), .overflow(overflow4)
  );

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic test_reset();
    SoftReset = 1'b1; clear = 1'b1; enable = 1'b1; mode = 1'b1;
    window_len = 16'd5; ch_event = '1;
    tick(); tick();
    checks++; if ({ref_count, ch_count, ch_snapshot} !== '0) begin errors++;
      $display("FAIL reset_counts got ref=%0d ch=%h snap=%h exp 0", ref_count, ch_count, ch_snapshot); end
    checks++; if ({snapshot_valid, busy, done, overflow} !== '0) begin errors++;
      $display("FAIL reset_flags got sv=%b busy=%b done=%b ovf=%b exp 0", snapshot_valid, busy, done, overflow); end
    SoftReset = 1'b0; clear = 1'b0; enable = 1'b0; ch_event = '0; mode = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_one_shot();
    window_len = 16'd10; mode = 1'b0; ch_event = 4'b0001; enable = 1'b1;
    tick();                      // edge k: enable_q set
    tick();                      // edge k+1: RUN
    checks++; if (busy !== 1'b1 || ref_count !== 16'd0) begin errors++;
      $display("FAIL oneshot_start got busy=%b ref=%0d exp busy=1 ref=0", busy, ref_count); end
    repeat (9) tick();           // edges k+2..k+10
    checks++; if (done !== 1'b0 || ref_count !== 16'd9) begin errors++;
      $display("FAIL oneshot_pre_end got done=%b ref=%0d exp done=0 ref=9", done, ref_count); end
    tick();                      // edge k+11
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ref_count !== 16'd10 || ch_count[0 +: W] !== 16'd10) begin errors++;
      $display("FAIL oneshot_end got done=%b busy=%b ref=%0d ch0=%0d exp 1 0 10 10", done, busy, ref_count, ch_count[0 +: W]); end
    repeat (2) tick();
    checks++; if (done !== 1'b1 || ch_count[0 +: W] !== 16'd10) begin errors++;
      $display("FAIL oneshot_hold got done=%b ch0=%0d exp 1 10", done, ch_count[0 +: W]); end
    enable = 1'b0; tick(); tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || ref_count !== 16'd10) begin errors++;
      $display("FAIL oneshot_idle got done=%b busy=%b ref=%0d exp 0 0 10", done, busy, ref_count); end
    ch_event = '0;
  endtask

  task automatic test_periodic();
    int mref = 0;
    int pulses = 0;
    logic [W-1:0] mcnt = '0;
    logic [W-1:0] e;
    logic ev;
    mode = 1'b1; window_len = 16'd4; ch_event = '0; enable = 1'b1;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      ev = (i % 2 == 0);
      ch_event = {2'b00, ev, 1'b0};
      if (ev) mcnt++;
      mref++;
      if (mref == 4) begin
        exp_q.push_back(mcnt);
        mcnt = '0;
        mref = 0;
      end
      tick();
      checks++; if (ch_count[W +: W] !== mcnt || ref_count !== W'(mref)) begin errors++;
        $display("FAIL periodic_live i=%0d got ch1=%0d ref=%0d exp %0d %0d", i, ch_count[W +: W], ref_count, mcnt, mref); end
      if (snapshot_valid) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin errors++;
          $display("FAIL periodic_snap i=%0d got unexpected pulse exp none", i);
        end else begin
          e = exp_q.pop_front();
          if (ch_snapshot[W +: W] !== e) begin errors++;
            $display("FAIL periodic_snap i=%0d got %0d exp %0d", i, ch_snapshot[W +: W], e); end
        end
      end
    end
    checks++; if (pulses !== 3 || exp_q.size() != 0 || busy !== 1'b1) begin errors++;
      $display("FAIL periodic_pulses got %0d left=%0d busy=%b exp 3 0 1", pulses, exp_q.size(), busy); end
    enable = 1'b0; ch_event = '0; tick(); tick();
  endtask

  task automatic test_enable_drop();
    int sv = 0;
    mode = 1'b0; window_len = 16'd100; ch_event = 4'b0001; enable = 1'b1;
    tick(); tick();              // RUN
    repeat (4) begin tick(); if (snapshot_valid) sv++; end
    enable = 1'b0;
    tick(); if (snapshot_valid) sv++;   // fifth count, enable_q drops
    tick(); if (snapshot_valid) sv++;   // back to IDLE
    checks++; if (busy !== 1'b0 || ref_count !== 16'd5 || ch_count[0 +: W] !== 16'd5) begin errors++;
      $display("FAIL drop_idle got busy=%b ref=%0d ch0=%0d exp 0 5 5", busy, ref_count, ch_count[0 +: W]); end
    repeat (3) begin tick(); if (snapshot_valid) sv++; end
    checks++; if (ref_count !== 16'd5 || sv !== 0) begin errors++;
      $display("FAIL drop_hold got ref=%0d pulses=%0d exp 5 0", ref_count, sv); end
    ch_event = '0;
  endtask

  task automatic test_clear_reset();
    window_len = 16'd100; mode = 1'b0; ch_event = 4'b0001; enable = 1'b1;
    tick(); tick(); repeat (7) tick();
    checks++; if (ch_count[0 +: W] !== 16'd7) begin errors++;
      $display("FAIL clr_pre got ch0=%0d exp 7", ch_count[0 +: W]); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if ({ref_count, ch_count, ch_snapshot, overflow, busy, done, snapshot_valid} !== '0) begin errors++;
      $display("FAIL clr_zero got ref=%0d ch=%h snap=%h ovf=%b busy=%b", ref_count, ch_count, ch_snapshot, overflow, busy); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL clr_rerun got busy=%b exp 1", busy); end
    repeat (7) tick();
    checks++; if (ch_count[0 +: W] !== 16'd7) begin errors++;
      $display("FAIL rst_pre got ch0=%0d exp 7", ch_count[0 +: W]); end
    SoftReset = 1'b1; tick(); SoftReset = 1'b0;
    checks++; if ({ref_count, ch_count, ch_snapshot, overflow, busy, done, snapshot_valid} !== '0) begin errors++;
      $display("FAIL rst_zero got ref=%0d ch=%h ovf=%b busy=%b", ref_count, ch_count, overflow, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_idle got busy=%b exp 0", busy); end
    tick(); repeat (7) tick();
    SoftReset = 1'b1; clear = 1'b1; tick(); SoftReset = 1'b0; clear = 1'b0;
    checks++; if ({ref_count, ch_count, busy, done, overflow} !== '0) begin errors++;
      $display("FAIL both_zero got ref=%0d ch=%h busy=%b", ref_count, ch_count, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL both_prio got busy=%b exp 0", busy); end
    enable = 1'b0; ch_event = '0; tick(); tick();
  endtask

  task automatic test_window_change();
    mode = 1'b0; window_len = 16'd10; ch_event = '0; enable = 1'b1;
    tick(); tick();
    window_len = 16'd3;
    repeat (9) tick();
    checks++; if (done !== 1'b0 || ref_count !== 16'd9) begin errors++;
      $display("FAIL wchg_mid got done=%b ref=%0d exp 0 9", done, ref_count); end
    tick();
    checks++; if (done !== 1'b1 || ref_count !== 16'd10) begin errors++;
      $display("FAIL wchg_end got done=%b ref=%0d exp 1 10", done, ref_count); end
    enable = 1'b0; tick(); tick();
  endtask

  task automatic test_overflow();
    clear = 1'b1; tick(); clear = 1'b0;
    mode = 1'b0; window_len = '0; ch_event = 4'b0100; enable = 1'b1;
    tick(); tick();
    repeat (15) tick();
    checks++; if (overflow4 !== '0 || ch_count4[2*W4 +: W4] !== 4'd15) begin errors++;
      $display("FAIL ovf_pre got ovf=%b ch2=%0d exp 0 15", overflow4, ch_count4[2*W4 +: W4]); end
    repeat (2) tick();
    checks++; if (overflow4 !== 5'b10100 || ch_count4[2*W4 +: W4] !== EXP_OVF_CNT) begin errors++;
      $display("FAIL ovf_w4 got ovf=%b ch2=%0d exp 10100 %0d", overflow4, ch_count4[2*W4 +: W4], EXP_OVF_CNT); end
    checks++; if (overflow !== '0 || ch_count[2*W +: W] !== 16'd17 || busy4 !== 1'b1) begin errors++;
      $display("FAIL ovf_w16 got ovf=%b ch2=%0d busy4=%b exp 0 17 1", overflow, ch_count[2*W +: W], busy4); end
    enable = 1'b0; ch_event = '0; tick(); tick();
    checks++; if (overflow4 !== 5'b10100) begin errors++;
      $display("FAIL ovf_sticky got %b exp 10100", overflow4); end
  endtask

  initial begin
    SoftReset = 1'b1; clear = 1'b0; enable = 1'b0; mode = 1'b0;
    window_len = '0; ch_event = '0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_drop();
    test_clear_reset();
    test_window_change();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
